// File: rtl/key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round keys, one per cycle,
// and serves registered reads of the stored schedule.

module keygeneration (
    input  logic [3:0]   rn,
    input  logic [127:0] kin,
    output logic [127:0] kout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box built from the GF(2^8) inverse (x^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a);
        inv  = gf_mul(x127, x127);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;
    logic [7:0]  rcon;

    always_comb begin
        rcon = 8'h00;
        case (rn)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign w0   = kin[127:96];
    assign w1   = kin[95:64];
    assign w2   = kin[63:32];
    assign w3   = kin[31:0];
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h000000};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;
    assign kout = {n0, n1, n2, n3};

endmodule

module key_schedule_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic         rk_strobe,
    output logic [3:0]   rk_idx,
    output logic [127:0] rk_data
);

    localparam logic [3:0] LAST_RN = 4'(NUM_ROUNDS - 1);
    localparam logic [3:0] MAX_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        EXPAND = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t       state, state_next;
    logic [3:0]   rn;
    logic [127:0] store [0:NUM_ROUNDS];
    logic [3:0]   gen_rn;
    logic [127:0] gen_kin, gen_kout;
    logic         accept, last;

    keygeneration u_keygen (
        .rn   (gen_rn),
        .kin  (gen_kin),
        .kout (gen_kout)
    );

    // Only a rn in 0..LAST_RN ever reaches the round block while expanding.
    assign gen_rn  = (state == EXPAND && rn <= LAST_RN) ? rn : 4'd0;
    assign gen_kin = store[gen_rn];
    assign busy    = (state == EXPAND);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (rn == LAST_RN) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rn         <= 4'd0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rk_strobe  <= 1'b0;
            rk_idx     <= 4'd0;
            rk_data    <= 128'h0;
            rd_key     <= 128'h0;
        end else begin
            state     <= state_next;
            done      <= 1'b0;
            rk_strobe <= 1'b0;
            if (accept) begin
                rn         <= 4'd0;
                keys_valid <= 1'b0;
                rk_strobe  <= 1'b1;
                rk_idx     <= 4'd0;
                rk_data    <= key_in;
            end else if (state == EXPAND) begin
                rn        <= rn + 4'd1;
                rk_strobe <= 1'b1;
                rk_idx    <= rn + 4'd1;
                rk_data   <= gen_kout;
                if (last) begin
                    done       <= 1'b1;
                    keys_valid <= 1'b1;
                end
            end
            rd_key <= (keys_valid && rd_addr <= MAX_IDX) ? store[rd_addr] : 128'h0;
        end
    end

    // The key store has no reset; readers are gated by keys_valid instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                store[0] <= key_in;
            end else if (state == EXPAND) begin
                store[rn + 4'd1] <= gen_kout;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl: FIPS-197 schedule, read sweep, restart/reset corner cases
// and back-to-back expansion with start held high.

module tb_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rd_addr;
    logic [127:0] rd_key;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic         rk_strobe;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;

    key_schedule_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .rd_addr    (rd_addr),
        .rd_key     (rd_key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_strobe  (rk_strobe),
        .rk_idx     (rk_idx),
        .rk_data    (rk_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp_key;
    } read_vec_t;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    localparam logic [127:0] ONES_R1  = 128'he8e9e9e917161616e8e9e9e917161616;

    logic [127:0] fips_keys [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    read_vec_t read_vecs [0:15];
    int assert_count = 0;
    int fail_count   = 0;
    int done_seen, first_done, second_done;

    task automatic applyStimulus(input logic start_v, input logic rst_v);
        start = start_v;
        rst   = rst_v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=%b required=%b", name, actual, expected);
        end
    endtask

    // Start an expansion of FIPS_KEY and check every cycle up to the done pulse.
    // A nonzero glitch_cycle pulses start with a different key in that cycle.
    task automatic expandAndCheck(input string tag, input int glitch_cycle);
        key_in = FIPS_KEY;
        applyStimulus(1'b1, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            checkBit($sformatf("%s busy c%0d", tag, c), busy, c <= 10);
            checkBit($sformatf("%s done c%0d", tag, c), done, c == 11);
            checkBit($sformatf("%s keys_valid c%0d", tag, c), keys_valid, c == 11);
            checkBit($sformatf("%s rk_strobe c%0d", tag, c), rk_strobe, 1'b1);
            checkOutput($sformatf("%s rk_idx c%0d", tag, c), 128'(rk_idx), 128'(c - 1));
            checkOutput($sformatf("%s rk_data c%0d", tag, c), rk_data, fips_keys[c - 1]);
            if (c == glitch_cycle) begin
                key_in = 128'h0;
                applyStimulus(1'b1, 1'b0);
                key_in = FIPS_KEY;
            end else if (c < 11) begin
                applyStimulus(1'b0, 1'b0);
            end
        end
        start = 1'b0;
    endtask

    task automatic readSweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_addr = read_vecs[i].addr;
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("%s rd_key[%0d]", tag, read_vecs[i].addr), rd_key, read_vecs[i].exp_key);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            read_vecs[i].addr    = 4'(i);
            read_vecs[i].exp_key = (i <= 10) ? fips_keys[i] : 128'h0;
        end

        start   = 1'b0;
        rst     = 1'b1;
        key_in  = 128'h0;
        rd_addr = 4'd0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkBit("reset busy", busy, 1'b0);
        checkBit("reset done", done, 1'b0);
        checkBit("reset keys_valid", keys_valid, 1'b0);
        checkBit("reset rk_strobe", rk_strobe, 1'b0);
        checkOutput("reset rk_idx", 128'(rk_idx), 128'h0);
        checkOutput("reset rk_data", rk_data, 128'h0);
        checkOutput("reset rd_key", rd_key, 128'h0);

        expandAndCheck("fips", 0);
        applyStimulus(1'b0, 1'b0);
        checkBit("post done pulse", done, 1'b0);
        checkBit("post rk_strobe", rk_strobe, 1'b0);
        checkBit("post keys_valid held", keys_valid, 1'b1);
        checkBit("post busy", busy, 1'b0);
        checkOutput("post rk_idx held", 128'(rk_idx), 128'd10);
        checkOutput("post rk_data held", rk_data, fips_keys[10]);
        readSweep("sweep1");

        expandAndCheck("restart_ignored", 5);
        readSweep("sweep2");

        // Reset in the middle of an expansion, then a clean expansion.
        rd_addr = 4'd0;
        key_in  = FIPS_KEY;
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkBit("midrst busy", busy, 1'b0);
        checkBit("midrst keys_valid", keys_valid, 1'b0);
        checkBit("midrst done", done, 1'b0);
        checkBit("midrst rk_strobe", rk_strobe, 1'b0);
        checkOutput("midrst rk_idx", 128'(rk_idx), 128'h0);
        checkOutput("midrst rd_key", rd_key, 128'h0);
        expandAndCheck("after_reset", 0);
        rd_addr = 4'd5;
        applyStimulus(1'b0, 1'b0);
        checkOutput("after_reset rd_key[5]", rd_key, fips_keys[5]);

        // start and rst together must leave the block idle.
        applyStimulus(1'b1, 1'b1);
        checkBit("rst+start busy", busy, 1'b0);
        checkBit("rst+start rk_strobe", rk_strobe, 1'b0);
        checkBit("rst+start keys_valid", keys_valid, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkBit("rst+start idle busy", busy, 1'b0);
        checkBit("rst+start idle rk_strobe", rk_strobe, 1'b0);

        // Zero key then all-ones key with start held high throughout.
        key_in      = 128'h0;
        done_seen   = 0;
        first_done  = 0;
        second_done = 0;
        applyStimulus(1'b1, 1'b0);
        for (int cyc = 1; cyc <= 40 && done_seen < 2; cyc++) begin
            if (cyc == 2) key_in = {128{1'b1}};
            if (rk_strobe && rk_idx == 4'd1) begin
                if (done_seen == 0) checkOutput("zero key rk1", rk_data, ZERO_R1);
                else checkOutput("ones key rk1", rk_data, ONES_R1);
            end
            if (done) begin
                if (done_seen == 0) begin
                    checkOutput("zero key rk10", rk_data, ZERO_R10);
                    first_done = cyc;
                end else begin
                    second_done = cyc;
                end
                done_seen++;
            end
            if (done_seen < 2) applyStimulus(1'b1, 1'b0);
        end
        start = 1'b0;
        checkOutput("b2b done count", 128'(done_seen), 128'd2);
        checkOutput("b2b done gap", 128'(second_done - first_done), 128'd11);
        rd_addr = 4'd1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("ones rd_key[1]", rd_key, ONES_R1);
        rd_addr = 4'd0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("ones rd_key[0]", rd_key, {128{1'b1}});

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
